// File: rtl/plane_eq_walker.sv
// Plane-equation tile walker: evaluates z = c + dzdx*x + dzdy*y per channel
// once per walk, then steps it across a raster of SIZE x SIZE tiles.
module plane_eq_walker #(
  parameter int SIZE  = 2,
  parameter int NATTR = 1,
  parameter int W     = 18,
  parameter int XW    = 16,
  parameter int CW    = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NATTR*W-1:0]          in_c,
  input  logic [NATTR*W-1:0]          in_dzdx,
  input  logic [NATTR*W-1:0]          in_dzdy,
  input  logic [XW-1:0]               in_x,
  input  logic [XW-1:0]               in_y,
  input  logic [CW-1:0]               in_tiles_x,
  input  logic [CW-1:0]               in_tiles_y,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NATTR*SIZE*SIZE*W-1:0] out_z,
  output logic [XW-1:0]               out_x,
  output logic [XW-1:0]               out_y,
  output logic                        out_last
);

  localparam int AW = W + XW + 3;

  typedef enum logic [1:0] {IDLE, SETUP, WALK} state_t;

  state_t state;

  logic signed [W-1:0]  c_r    [NATTR];
  logic signed [W-1:0]  dzdx_r [NATTR];
  logic signed [W-1:0]  dzdy_r [NATTR];
  logic [XW-1:0]        x0, y0;
  logic [CW-1:0]        tx_max, ty_max, tx, ty;
  logic signed [AW-1:0] zt     [NATTR];
  logic signed [AW-1:0] zrow   [NATTR];

  logic signed [AW-1:0] c_e    [NATTR];
  logic signed [AW-1:0] dx_e   [NATTR];
  logic signed [AW-1:0] dy_e   [NATTR];
  logic signed [AW-1:0] z0     [NATTR];
  logic signed [AW-1:0] znext  [NATTR];
  logic signed [AW-1:0] zsel   [NATTR];
  logic [NATTR*SIZE*SIZE*W-1:0] tile_z;
  logic                 col_wrap, next_last;

  function automatic logic [W-1:0] sat(input logic signed [AW-1:0] v);
    logic signed [AW-1:0] hi, lo;
    hi = $signed({{(AW-W+1){1'b0}}, {(W-1){1'b1}}});
    lo = ~hi;
    if (v > hi)      sat = hi[W-1:0];
    else if (v < lo) sat = lo[W-1:0];
    else             sat = v[W-1:0];
  endfunction

  assign in_ready = (state == IDLE) && !rst;

  always_comb begin
    for (int a = 0; a < NATTR; a++) begin
      c_e[a]  = $signed({{(AW-W){c_r[a][W-1]}}, c_r[a]});
      dx_e[a] = $signed({{(AW-W){dzdx_r[a][W-1]}}, dzdx_r[a]});
      dy_e[a] = $signed({{(AW-W){dzdy_r[a][W-1]}}, dzdy_r[a]});
      z0[a]   = c_e[a] + dx_e[a] * $signed({{(AW-XW){1'b0}}, x0})
                       + dy_e[a] * $signed({{(AW-XW){1'b0}}, y0});
    end
  end

  // Next tile origin: column step from the current tile, row step from row start.
  always_comb begin
    col_wrap = (tx == tx_max);
    if (col_wrap)
      next_last = (tx_max == '0) && ((ty + CW'(1)) == ty_max);
    else
      next_last = ((tx + CW'(1)) == tx_max) && (ty == ty_max);
    for (int a = 0; a < NATTR; a++) begin
      if (col_wrap) znext[a] = zrow[a] + dy_e[a] * AW'(SIZE);
      else          znext[a] = zt[a] + dx_e[a] * AW'(SIZE);
      zsel[a] = out_valid ? znext[a] : zt[a];
    end
  end

  always_comb begin
    tile_z = '0;
    for (int a = 0; a < NATTR; a++)
      for (int j = 0; j < SIZE; j++)
        for (int i = 0; i < SIZE; i++)
          tile_z[((a*SIZE + j)*SIZE + i)*W +: W] =
            sat(zsel[a] + dx_e[a] * AW'(i) + dy_e[a] * AW'(j));
  end

  // Outputs are fully registered, so out_valid never depends on out_ready
  // combinationally and a stalled tile simply holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_z     <= '0;
      out_x     <= '0;
      out_y     <= '0;
      x0        <= '0;
      y0        <= '0;
      tx_max    <= '0;
      ty_max    <= '0;
      tx        <= '0;
      ty        <= '0;
      for (int a = 0; a < NATTR; a++) begin
        c_r[a]    <= '0;
        dzdx_r[a] <= '0;
        dzdy_r[a] <= '0;
        zt[a]     <= '0;
        zrow[a]   <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            for (int a = 0; a < NATTR; a++) begin
              c_r[a]    <= in_c[a*W +: W];
              dzdx_r[a] <= in_dzdx[a*W +: W];
              dzdy_r[a] <= in_dzdy[a*W +: W];
            end
            x0     <= in_x;
            y0     <= in_y;
            tx_max <= (in_tiles_x == '0) ? '0 : in_tiles_x - CW'(1);
            ty_max <= (in_tiles_y == '0) ? '0 : in_tiles_y - CW'(1);
            state  <= SETUP;
          end
        end
        SETUP: begin
          for (int a = 0; a < NATTR; a++) begin
            zt[a]   <= z0[a];
            zrow[a] <= z0[a];
          end
          tx    <= '0;
          ty    <= '0;
          state <= WALK;
        end
        WALK: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_z     <= tile_z;
            out_x     <= x0;
            out_y     <= y0;
            out_last  <= (tx_max == '0) && (ty_max == '0);
          end else if (out_ready) begin
            if (out_last) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              state     <= IDLE;
            end else begin
              for (int a = 0; a < NATTR; a++) begin
                zt[a] <= znext[a];
                if (col_wrap) zrow[a] <= znext[a];
              end
              if (col_wrap) begin
                tx    <= '0;
                ty    <= ty + CW'(1);
                out_x <= x0;
                out_y <= out_y + XW'(SIZE);
              end else begin
                tx    <= tx + CW'(1);
                out_x <= out_x + XW'(SIZE);
              end
              out_z    <= tile_z;
              out_last <= next_last;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_plane_eq_walker.sv
// Directed bench for plane_eq_walker (SIZE=2, NATTR=2): 1x1 vector table
// plus raster walk, stall and mid-walk reset sequences.
module tb_plane_eq_walker;
  localparam int SIZE = 2, NATTR = 2, W = 18, XW = 16, CW = 8;

  logic                         clk = 1'b0;
  logic                         rst;
  logic                         in_valid, in_ready;
  logic [NATTR*W-1:0]           in_c, in_dzdx, in_dzdy;
  logic [XW-1:0]                in_x, in_y;
  logic [CW-1:0]                in_tiles_x, in_tiles_y;
  logic                         out_valid, out_ready, out_last;
  logic [NATTR*SIZE*SIZE*W-1:0] out_z;
  logic [XW-1:0]                out_x, out_y;

  int passCount = 0;
  int checkCount = 0;

  typedef struct {
    logic signed [W-1:0] c0, dx0, dy0, c1, dx1, dy1;
    logic [XW-1:0]       x, y;
    logic [CW-1:0]       ntx, nty;
    int a00, a01, a10, a11;
    int b00, b01, b10, b11;
    int ex, ey;
  } vec_t;

  vec_t vecs [6];
  int xs [6];
  int ys [6];
  int zs [6];

  plane_eq_walker #(.SIZE(SIZE), .NATTR(NATTR), .W(W), .XW(XW), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_c(in_c), .in_dzdx(in_dzdx), .in_dzdy(in_dzdy),
    .in_x(in_x), .in_y(in_y), .in_tiles_x(in_tiles_x), .in_tiles_y(in_tiles_y),
    .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z),
    .out_x(out_x), .out_y(out_y), .out_last(out_last)
  );

  always #5 clk = ~clk;

  function automatic int zval(int a, int j, int i);
    logic signed [W-1:0] t;
    t = out_z[((a*SIZE + j)*SIZE + i)*W +: W];
    return int'(t);
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual == expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  // Accepts one setup and verifies the two-cycle latency to the first tile.
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    checkOutput("in_ready idle", int'(in_ready), 1);
    in_valid = 1'b1;
    in_c = {v.c1, v.c0};
    in_dzdx = {v.dx1, v.dx0};
    in_dzdy = {v.dy1, v.dy0};
    in_x = v.x;
    in_y = v.y;
    in_tiles_x = v.ntx;
    in_tiles_y = v.nty;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("out_valid accept+1", int'(out_valid), 0);
    checkOutput("in_ready busy", int'(in_ready), 0);
    @(negedge clk);
    checkOutput("out_valid accept+1.5", int'(out_valid), 0);
    @(negedge clk);
    checkOutput("out_valid accept+2", int'(out_valid), 1);
  endtask

  task automatic checkVector(input vec_t v, input int k);
    checkOutput($sformatf("v%0d z0[0][0]", k), zval(0, 0, 0), v.a00);
    checkOutput($sformatf("v%0d z0[0][1]", k), zval(0, 0, 1), v.a01);
    checkOutput($sformatf("v%0d z0[1][0]", k), zval(0, 1, 0), v.a10);
    checkOutput($sformatf("v%0d z0[1][1]", k), zval(0, 1, 1), v.a11);
    checkOutput($sformatf("v%0d z1[0][0]", k), zval(1, 0, 0), v.b00);
    checkOutput($sformatf("v%0d z1[0][1]", k), zval(1, 0, 1), v.b01);
    checkOutput($sformatf("v%0d z1[1][0]", k), zval(1, 1, 0), v.b10);
    checkOutput($sformatf("v%0d z1[1][1]", k), zval(1, 1, 1), v.b11);
    checkOutput($sformatf("v%0d out_x", k), int'(out_x), v.ex);
    checkOutput($sformatf("v%0d out_y", k), int'(out_y), v.ey);
    checkOutput($sformatf("v%0d out_last", k), int'(out_last), 1);
  endtask

  task automatic acceptLast();
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("out_valid after last", int'(out_valid), 0);
    checkOutput("in_ready after last", int'(in_ready), 1);
    out_ready = 1'b0;
  endtask

  // Tile b of the 3x2 walk with dzdx=2048, dzdy=1024 on channel 0.
  task automatic checkBeat(input int b);
    checkOutput($sformatf("beat%0d out_valid", b+1), int'(out_valid), 1);
    checkOutput($sformatf("beat%0d out_x", b+1), int'(out_x), xs[b]);
    checkOutput($sformatf("beat%0d out_y", b+1), int'(out_y), ys[b]);
    checkOutput($sformatf("beat%0d z[0][0]", b+1), zval(0, 0, 0), zs[b]);
    checkOutput($sformatf("beat%0d z[0][1]", b+1), zval(0, 0, 1), zs[b] + 2048);
    checkOutput($sformatf("beat%0d z[1][0]", b+1), zval(0, 1, 0), zs[b] + 1024);
    checkOutput($sformatf("beat%0d z[1][1]", b+1), zval(0, 1, 1), zs[b] + 3072);
    checkOutput($sformatf("beat%0d out_last", b+1), int'(out_last), (b == 5) ? 1 : 0);
  endtask

  task automatic startWalk(input bit junk);
    @(negedge clk);
    checkOutput("walk in_ready", int'(in_ready), 1);
    in_valid = 1'b1;
    in_c = '0;
    in_dzdx = {18'sd0, 18'sd2048};
    in_dzdy = {18'sd0, 18'sd1024};
    in_x = '0;
    in_y = '0;
    in_tiles_x = 8'd3;
    in_tiles_y = 8'd2;
    out_ready = 1'b0;
    @(negedge clk);
    if (junk) begin
      in_c = {18'sd999, 18'sd999};
      in_x = 16'd77;
      in_tiles_x = 8'd1;
      in_tiles_y = 8'd1;
    end else begin
      in_valid = 1'b0;
    end
    @(negedge clk);
    checkOutput("walk out_valid pre", int'(out_valid), 0);
    out_ready = 1'b1;
  endtask

  task automatic runWalk(input int stallBeat, input int stallCycles, input bit junk);
    startWalk(junk);
    for (int b = 0; b < 6; b++) begin
      @(negedge clk);
      checkBeat(b);
      if (b == 5) in_valid = 1'b0;
      if (b == stallBeat) begin
        out_ready = 1'b0;
        repeat (stallCycles) begin
          @(negedge clk);
          checkBeat(b);
        end
        out_ready = 1'b1;
      end
    end
    @(negedge clk);
    checkOutput("walk end out_valid", int'(out_valid), 0);
    checkOutput("walk end in_ready", int'(in_ready), 1);
    @(negedge clk);
    checkOutput("walk idle out_valid", int'(out_valid), 0);
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int stray;
    vecs[0] = '{18'sd0, 18'sd2048, 18'sd1024, 18'sd512, 18'sd0, -18'sd1024,
                16'd1, 16'd0, 8'd1, 8'd1,
                2048, 4096, 3072, 5120, 512, 512, -512, -512, 1, 0};
    vecs[1] = '{18'sd131071, 18'sd2048, 18'sd0, 18'sd0, 18'sd0, 18'sd0,
                16'd10, 16'd0, 8'd1, 8'd1,
                131071, 131071, 131071, 131071, 0, 0, 0, 0, 10, 0};
    vecs[2] = '{-18'sd131072, -18'sd2048, 18'sd0, 18'sd0, 18'sd0, 18'sd0,
                16'd10, 16'd0, 8'd1, 8'd1,
                -131072, -131072, -131072, -131072, 0, 0, 0, 0, 10, 0};
    vecs[3] = '{18'sd100, -18'sd3, 18'sd7, -18'sd50, 18'sd10, 18'sd1,
                16'd5, 16'd3, 8'd0, 8'd0,
                106, 103, 113, 110, 3, 13, 4, 14, 5, 3};
    vecs[4] = '{18'sd0, 18'sd1, 18'sd0, 18'sd0, 18'sd0, -18'sd1,
                16'd65535, 16'd0, 8'd1, 8'd1,
                65535, 65536, 65535, 65536, 0, 0, -1, -1, 65535, 0};
    vecs[5] = '{18'sd131000, 18'sd100, 18'sd0, 18'sd0, 18'sd0, 18'sd0,
                16'd0, 16'd0, 8'd1, 8'd1,
                131000, 131071, 131000, 131071, 0, 0, 0, 0, 0, 0};
    xs = '{0, 2, 4, 0, 2, 4};
    ys = '{0, 0, 0, 2, 2, 2};
    zs = '{0, 4096, 8192, 2048, 6144, 10240};

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_c = '0;
    in_dzdx = '0;
    in_dzdy = '0;
    in_x = '0;
    in_y = '0;
    in_tiles_x = '0;
    in_tiles_y = '0;
    #1;
    checkOutput("reset in_ready", int'(in_ready), 0);
    checkOutput("reset out_valid", int'(out_valid), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("post-reset in_ready", int'(in_ready), 1);
    checkOutput("post-reset out_x", int'(out_x), 0);
    checkOutput("post-reset out_last", int'(out_last), 0);

    for (int k = 0; k < 6; k++) begin
      applyStimulus(vecs[k]);
      checkVector(vecs[k], k);
      acceptLast();
    end

    $display("[TB] raster walk with in_valid held busy");
    runWalk(-1, 0, 1'b1);
    $display("[TB] raster walk with stall on beat 2");
    runWalk(1, 5, 1'b0);

    $display("[TB] reset during beat 3");
    startWalk(1'b0);
    for (int b = 0; b < 3; b++) begin
      @(negedge clk);
      checkBeat(b);
    end
    #1 rst = 1'b1;
    #1;
    checkOutput("mid-walk reset out_valid", int'(out_valid), 0);
    checkOutput("mid-walk reset in_ready", int'(in_ready), 0);
    checkOutput("mid-walk reset out_x", int'(out_x), 0);
    checkOutput("mid-walk reset out_y", int'(out_y), 0);
    checkOutput("mid-walk reset out_last", int'(out_last), 0);
    checkOutput("mid-walk reset out_z zero", int'(out_z == '0), 1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("release in_ready", int'(in_ready), 1);
    stray = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) stray++;
    end
    checkOutput("tiles after reset", stray, 0);
    out_ready = 1'b0;
    applyStimulus(vecs[0]);
    checkVector(vecs[0], 6);
    acceptLast();

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/plane_eq_walker.md
PLANE_EQ_WALKER -- requirements
Module: plane_eq_walker

Interface
REQ-001 SHALL have parameters: SIZE, default 2, tile edge in pixels (1..16); NATTR, default 1, attribute channel count; W, default 18, attribute width (signed, 11 fractional bits); XW, default 16, coordinate width (unsigned integer); CW, default 8, tile-count width.
REQ-002 SHALL have ports:
- clk  in  1  sole clock, all state on rising edge
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  setup request valid
- in_ready  out  1  setup request accepted when in_valid&&in_ready
- in_c  in  NATTR*W  per-channel plane constant c
- in_dzdx  in  NATTR*W  per-channel x gradient
- in_dzdy  in  NATTR*W  per-channel y gradient
- in_x  in  XW  x of first tile origin
- in_y  in  XW  y of first tile origin
- in_tiles_x  in  CW  tiles per row (0 treated as 1)
- in_tiles_y  in  CW  tile rows (0 treated as 1)
- out_valid  out  1  tile result valid
- out_ready  in  1  downstream accepts tile
- out_z  out  NATTR*SIZE*SIZE*W  z[a][j][i], j = row, i = column within tile
- out_x  out  XW  tile origin x
- out_y  out  XW  tile origin y
- out_last  out  1  final tile of the walk

Function
REQ-003 SHALL have FSM states IDLE, SETUP, WALK; in_ready = 1 only in IDLE.
REQ-004 IDLE -> SETUP on in_valid&&in_ready; all in_* fields captured that edge.
REQ-005 SETUP (one cycle) SHALL compute per channel z0 = c + dzdx*x + dzdy*y in signed accumulator of W+XW+3 bits, no intermediate truncation; -> WALK.
REQ-006 First out_valid SHALL assert exactly 2 cycles after the accepting edge.
REQ-007 Walk order raster: tile column tx fast (0..tiles_x-1), row ty slow (0..tiles_y-1).
REQ-008 out_x = x0 + tx*SIZE, out_y = y0 + ty*SIZE, both modulo 2^XW.
REQ-009 Tile origin value SHALL update incrementally: +dzdx*SIZE per column step; on row change, row-start value + dzdy*SIZE; no multiplier in WALK beyond constant-SIZE shifts/adds.
REQ-010 out_z[a][j][i] = sat_W(zt[a] + i*dzdx[a] + j*dzdy[a]), sat_W clamping to [-2^(W-1), 2^(W-1)-1]; accumulator never saturates.
REQ-011 Advance to next tile only on out_valid&&out_ready; one tile per cycle under continuous out_ready.
REQ-012 While out_valid&&!out_ready, out_z, out_x, out_y, out_last SHALL hold stable.
REQ-013 out_last = 1 only on tile (tiles_x-1, tiles_y-1); its acceptance -> IDLE, out_valid = 0 next cycle.
REQ-014 in_valid SHALL be ignored outside IDLE; new walk never disturbs current one.
REQ-015 out_valid SHALL not depend combinationally on out_ready.

Reset
REQ-016 rst asserted (any state, including mid-walk) SHALL immediately force IDLE, out_valid = 0, out_last = 0, out_z = 0, out_x = 0, out_y = 0, counters = 0.
REQ-017 in_ready SHALL be 0 while rst high, 1 the first cycle after deassertion.
REQ-018 In-flight walk SHALL be discarded on reset; no tile emitted after rst release until new setup accepted.

Verification
REQ-019 SIZE=2, NATTR=1, c=0, dzdx=2048, dzdy=1024, x=1, y=0, tiles 1x1 -> 2 cycles after accept: z[0][0]=2048, z[0][1]=4096, z[1][0]=3072, z[1][1]=5120, out_x=1, out_y=0, out_last=1.
REQ-020 Same planes, x=0, y=0, tiles 3x2, out_ready=1 -> 6 consecutive beats, (out_x,out_y) = (0,0),(2,0),(4,0),(0,2),(2,2),(4,2); z[0][0] = 0,4096,8192,2048,6144,10240; out_last only on beat 6; in_ready=1 next cycle.
REQ-021 Tiles 3x2, out_ready low for 5 cycles on beat 2 -> beat 2 fields bit-stable throughout; sequence otherwise identical to REQ-020.
REQ-022 c=131071, dzdx=2048, x=10, tiles 1x1 -> all z = 131071; c=-131072, dzdx=-2048, x=10 -> all z = -131072.
REQ-023 NATTR=2, channel 0 as REQ-019, channel 1 c=512, dzdx=0, dzdy=-1024 -> channel 0 per REQ-019; channel 1 z = 512, 512, -512, -512 ([0][0],[0][1],[1][0],[1][1]).
REQ-024 rst pulsed during beat 3 of 3x2 walk -> out_valid=0 same cycle, in_ready=1 first cycle after release, no further tiles; new 1x1 setup then yields REQ-019 result.
